mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single unified memory bus of the multi-cycle RISC-V core between two requesters:
  - the instruction-fetch port (IF), read-only;
  - the load/store port (LS), read/write.
- Drives the memory-map decoder's MemRead/MemWrite/AddrIn/DataIn inputs and returns its DataOut to the winning requester.
- Sequences each access over a fixed memory latency.
- Arbitration is fixed priority (LS first), with a starvation guard that protects instruction fetch.

Parameters:
- RD_LATENCY, 1, cycles the bus is held per access (synchronous RAM read latency); legal range 1..7.
- MAX_LS_STREAK, 4, consecutive LS grants allowed while IF is pending before IF is forced to win; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  IF request; held until if_ack
- if_addr  in  32  IF byte address; stable while if_req is high
- if_rdata  out  32  IF read data; valid in the if_ack cycle, held until the next if_ack
- if_ack  out  1  one-cycle completion pulse
- if_err  out  1  pulses with if_ack when the address is in the reserved region
- ls_req  in  1  LS request; held until ls_ack
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  32  LS byte address
- ls_wdata  in  32  store data
- ls_rdata  out  32  load data; held until the next ls_ack
- ls_ack  out  1  one-cycle completion pulse
- ls_err  out  1  pulses with ls_ack on a reserved-region address
- bus_read  out  1  to decoder MemRead
- bus_write  out  1  to decoder MemWrite
- bus_addr  out  32  to decoder AddrIn
- bus_wdata  out  32  to decoder DataIn
- bus_rdata  in  32  from decoder DataOut

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state IDLE; every output 0; streak counter 0; latency counter 0.
- rst mid-access: the access is abandoned with no ack, and the bus strobes drop in the next cycle.
- State machine: IDLE, ACCESS, RESP.
- IDLE:
  - Arbitration winner:
    - If LS and IF both request and the streak count is below MAX_LS_STREAK, LS wins.
    - If the streak count equals MAX_LS_STREAK, IF wins.
    - A single requester always wins.
  - Winner's address, write data, write enable and port id are registered; go to ACCESS.
  - No request: stay in IDLE.
- Reserved address (addr <= 0x003F_FFFF):
  - Skip ACCESS and go directly to RESP.
  - No bus strobe, rdata = 0, err = 1.
- ACCESS:
  - bus_addr and bus_wdata come from registers.
  - bus_read = 1 for every cycle of a load or fetch.
  - bus_write = 1 only in the last ACCESS cycle of a store.
  - Lasts RD_LATENCY cycles, counted by the latency counter.
  - On the last cycle, bus_rdata is captured into the granted port's rdata register (loads and fetches only); go to RESP.
- RESP:
  - Granted port's ack = 1 for exactly one cycle; strobes are 0.
  - Requests are ignored; go to IDLE.
- Latency: req sampled in IDLE at cycle N gives ack at N+1+RD_LATENCY (N+2 by default).
- Throughput:
  - Maximum one access per RD_LATENCY+2 cycles.
  - A requester that keeps req high after ack is treated as a new request; it must present the new address in the cycle after ack.
- Streak counter:
  - Increments on an LS grant made while if_req = 1.
  - Clears on any IF grant, or on an LS grant made while if_req = 0.
  - Saturates at MAX_LS_STREAK.
- The non-granted port's ack, err and rdata are never disturbed.
- Any IF address above 0x0FFF_FFFF is still forwarded to the bus; the decoder decides the target.

Optional Feature:
- Macro: MEM_BUS_ARB_STATS_EN
- With the macro defined, three extra 32-bit outputs are added:
  - if_grant_cnt: counts IF grants;
  - ls_grant_cnt: counts LS grants;
  - contention_cnt: counts IDLE cycles in which both requesters were present.
- All three reset to 0 on rst and wrap at 2^32.
- Without the macro: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package mem_bus_pkg:
  - state enum {IDLE, ACCESS, RESP};
  - port-id enum {PORT_IF, PORT_LS};
  - constant ADDR_RESERVED_MAX = 32'h003F_FFFF.
- Sub-module mem_bus_prio_sel (combinational):
  - inputs: if_req, ls_req, streak_full;
  - outputs: grant_valid, grant_port.
- The FSM, counters and data registers stay in the top module.

Test Plan:
- Lone LS load, ls_addr = 0x1001_0000, bus_rdata = 0xDEAD_BEEF → bus_read high for 1 cycle, ls_ack 2 cycles after req, ls_rdata = 0xDEAD_BEEF, if_* untouched.
- Lone LS store, ls_addr = 0x1001_0024, ls_wdata = 0x55 → bus_write pulses exactly once with bus_wdata = 0x55; bus_read stays 0; ls_ack follows.
- if_req and ls_req held high continuously (MAX_LS_STREAK = 4) → grant order LS, LS, LS, LS, IF, repeating; no more than 4 LS acks between IF acks.
- if_addr = 0x0000_1000 → if_ack and if_err together 1 cycle after req; if_rdata = 0; no bus strobe.
- rst asserted during ACCESS (RD_LATENCY = 3) → next cycle all strobes and acks are 0 and state is IDLE; a new request completes normally afterwards.
- With MEM_BUS_ARB_STATS_EN: 3 IF grants, 5 LS grants and 4 contention cycles → counters read 3, 5 and 4; rst clears all three.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the unified memory-bus arbiter.
// Contents: FSM state enum, requester port id, reserved-region bound and
// the address classification helper used by the top module.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      PORT_IF = 1'b0,
      PORT_LS = 1'b1
   } port_t;

   // Addresses at or below this bound map to nothing; accesses there are
   // answered locally with an error and never reach the decoder.
   localparam logic [31:0] ADDR_RESERVED_MAX = 32'h003F_FFFF;

   function automatic logic is_reserved(input logic [31:0] addr);
      return (addr <= ADDR_RESERVED_MAX);
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Handshake and bus signal bundle for mem_bus_arbiter.
// slave  : arbiter side (takes IF/LS requests, drives the decoder bus).
// master : requester/memory side (drives requests, returns bus_rdata).
interface mem_bus_arbiter_if;

   // instruction-fetch port (read-only)
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        if_err;

   // load/store port
   logic        ls_req;
   logic        ls_we;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic [31:0] ls_rdata;
   logic        ls_ack;
   logic        ls_err;

   // memory-map decoder side
   logic        bus_read;
   logic        bus_write;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_rdata, if_ack, if_err,
      input  ls_req, ls_we, ls_addr, ls_wdata,
      output ls_rdata, ls_ack, ls_err,
      output bus_read, bus_write, bus_addr, bus_wdata,
      input  bus_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_rdata, if_ack, if_err,
      output ls_req, ls_we, ls_addr, ls_wdata,
      input  ls_rdata, ls_ack, ls_err,
      input  bus_read, bus_write, bus_addr, bus_wdata,
      output bus_rdata
   );

endinterface

// File: rtl/mem_bus_prio_sel.sv
// Fixed-priority requester select: LS first unless its streak is exhausted.
// Latency: combinational.
// Backpressure: none; the caller decides when the grant is taken.
// Ports: if_req, ls_req, streak_full in; grant_valid, grant_port out.
module mem_bus_prio_sel
   import mem_bus_pkg::*;
(
   input  logic  if_req,
   input  logic  ls_req,
   input  logic  streak_full,
   output logic  grant_valid,
   output port_t grant_port
);

   always_comb begin
      grant_valid = if_req | ls_req;
      grant_port  = PORT_IF;
      // A full streak only hands the bus to IF when IF is actually waiting;
      // a lone LS request always wins.
      if (ls_req && !(if_req && streak_full)) begin
         grant_port = PORT_LS;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter (IF fetch, LS load/store) for the unified memory bus.
// Latency: request seen in IDLE at cycle N is acked at N+1+RD_LATENCY (N+1 for reserved).
// Backpressure: requesters hold req until their one-cycle ack; one access in flight.
// Ports: clk, rst (sync, active-high), mb (mem_bus_arbiter_if.slave).
// Optional: MEM_BUS_ARB_STATS_EN adds if_grant_cnt, ls_grant_cnt, contention_cnt.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int RD_LATENCY    = 1,   // 1..7
   parameter int MAX_LS_STREAK = 4    // 1..15
)
(
   input  logic              clk,
   input  logic              rst,
   mem_bus_arbiter_if.slave  mb
`ifdef MEM_BUS_ARB_STATS_EN
   ,
   output logic [31:0]       if_grant_cnt,
   output logic [31:0]       ls_grant_cnt,
   output logic [31:0]       contention_cnt
`endif
);

   localparam logic [2:0] LAT_LAST   = 3'(RD_LATENCY - 1);
   localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

   state_t      state_q, state_d;
   port_t       port_q;
   logic        we_q;
   logic        err_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [2:0]  lat_q;
   logic [3:0]  streak_q;
   logic [31:0] if_rdata_q;
   logic [31:0] ls_rdata_q;

   logic        grant_valid;
   port_t       grant_port;
   logic        streak_full;
   logic        grant_fire;
   logic        lat_last;
   logic [31:0] grant_addr;
   logic        grant_rsvd;

   assign streak_full = (streak_q == STREAK_MAX);
   assign lat_last    = (lat_q == LAT_LAST);
   assign grant_addr  = (grant_port == PORT_LS) ? mb.ls_addr : mb.if_addr;
   assign grant_rsvd  = is_reserved(grant_addr);

   mem_bus_prio_sel u_prio_sel (
      .if_req      (mb.if_req),
      .ls_req      (mb.ls_req),
      .streak_full (streak_full),
      .grant_valid (grant_valid),
      .grant_port  (grant_port)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_fire = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               grant_fire = 1'b1;
               state_d    = grant_rsvd ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            if (lat_last) begin
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         port_q     <= PORT_IF;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         lat_q      <= 3'd0;
         streak_q   <= 4'd0;
         if_rdata_q <= 32'h0;
         ls_rdata_q <= 32'h0;
      end else begin
         if (grant_fire) begin
            port_q  <= grant_port;
            addr_q  <= grant_addr;
            err_q   <= grant_rsvd;
            lat_q   <= 3'd0;
            we_q    <= (grant_port == PORT_LS) && mb.ls_we;
            wdata_q <= (grant_port == PORT_LS) ? mb.ls_wdata : 32'h0;

            // Streak only grows while IF is actually being held off.
            if (grant_port == PORT_LS && mb.if_req) begin
               if (!streak_full) begin
                  streak_q <= streak_q + 4'd1;
               end
            end else begin
               streak_q <= 4'd0;
            end

            // Reserved accesses return zero data to the granted port only.
            if (grant_rsvd) begin
               if (grant_port == PORT_LS) begin
                  ls_rdata_q <= 32'h0;
               end else begin
                  if_rdata_q <= 32'h0;
               end
            end
         end

         if (state_q == ACCESS) begin
            lat_q <= lat_last ? 3'd0 : lat_q + 3'd1;
            if (lat_last && !we_q) begin
               if (port_q == PORT_LS) begin
                  ls_rdata_q <= mb.bus_rdata;
               end else begin
                  if_rdata_q <= mb.bus_rdata;
               end
            end
         end
      end
   end

   // ---------------- outputs ----------------
   // Strobes and acks decode straight from the registered state so a reset
   // drops them in the very next cycle.
   assign mb.bus_read  = (state_q == ACCESS) && !we_q;
   assign mb.bus_write = (state_q == ACCESS) && we_q && lat_last;
   assign mb.bus_addr  = addr_q;
   assign mb.bus_wdata = wdata_q;

   assign mb.if_ack   = (state_q == RESP) && (port_q == PORT_IF);
   assign mb.if_err   = mb.if_ack && err_q;
   assign mb.if_rdata = if_rdata_q;

   assign mb.ls_ack   = (state_q == RESP) && (port_q == PORT_LS);
   assign mb.ls_err   = mb.ls_ack && err_q;
   assign mb.ls_rdata = ls_rdata_q;

`ifdef MEM_BUS_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         if_grant_cnt   <= 32'h0;
         ls_grant_cnt   <= 32'h0;
         contention_cnt <= 32'h0;
      end else begin
         if (grant_fire && grant_port == PORT_IF) begin
            if_grant_cnt <= if_grant_cnt + 32'd1;
         end
         if (grant_fire && grant_port == PORT_LS) begin
            ls_grant_cnt <= ls_grant_cnt + 32'd1;
         end
         if (state_q == IDLE && mb.if_req && mb.ls_req) begin
            contention_cnt <= contention_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: default instance (RD_LATENCY=1)
// plus a RD_LATENCY=3 instance for the reset-during-access scenario.
module tb_mem_bus_arbiter;
   import mem_bus_pkg::*;

   localparam int RD_LAT     = 1;
   localparam int RD_LAT3    = 3;
   localparam int MAX_STREAK = 4;
   localparam logic [31:0] IF_A = 32'h0040_0000;
   localparam logic [31:0] LS_A = 32'h1001_0010;

   typedef struct {
      int          lat;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic rst3;
   int   n_pass  = 0;
   int   n_total = 0;
   int   m_streak = 0;
   logic [31:0] m_if_rdata = 32'h0;
   logic [31:0] m_ls_rdata = 32'h0;
   exp_t  exp_q[$];
   port_t ord_q[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] rdata_fn(input logic [31:0] a);
      return (a == 32'h1001_0000) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_A5A5);
   endfunction

   mem_bus_arbiter_if b();
   mem_bus_arbiter_if b3();
   assign b.bus_rdata  = rdata_fn(b.bus_addr);
   assign b3.bus_rdata = rdata_fn(b3.bus_addr);

`ifdef MEM_BUS_ARB_STATS_EN
   logic [31:0] if_gc, ls_gc, cont_c, if_gc3, ls_gc3, cont_c3;
`endif

   mem_bus_arbiter #(.RD_LATENCY(RD_LAT), .MAX_LS_STREAK(MAX_STREAK)) dut (
      .clk (clk), .rst (rst), .mb (b)
`ifdef MEM_BUS_ARB_STATS_EN
      , .if_grant_cnt (if_gc), .ls_grant_cnt (ls_gc), .contention_cnt (cont_c)
`endif
   );

   mem_bus_arbiter #(.RD_LATENCY(RD_LAT3), .MAX_LS_STREAK(MAX_STREAK)) dut3 (
      .clk (clk), .rst (rst3), .mb (b3)
`ifdef MEM_BUS_ARB_STATS_EN
      , .if_grant_cnt (if_gc3), .ls_grant_cnt (ls_gc3), .contention_cnt (cont_c3)
`endif
   );

   // ---------------------------------------------------------------
   task automatic test_reset();
      logic [31:0] outs;
      rst = 1'b1;
      b.ls_req = 1'b1; b.ls_we = 1'b1; b.ls_addr = 32'h1001_0000; b.ls_wdata = 32'h1;
      repeat (3) @(negedge clk);
      outs = {30'h0, b.if_ack, b.if_err} | {30'h0, b.ls_ack, b.ls_err}
           | {30'h0, b.bus_read, b.bus_write};
      n_total++;
      if (outs !== 32'h0) $display("FAIL reset_strobes: got %h want 0", outs);
      else n_pass++;
      n_total++;
      if ((b.if_rdata | b.ls_rdata | b.bus_addr | b.bus_wdata) !== 32'h0)
         $display("FAIL reset_data: got %h/%h/%h/%h want 0", b.if_rdata, b.ls_rdata, b.bus_addr, b.bus_wdata);
      else n_pass++;
`ifdef MEM_BUS_ARB_STATS_EN
      n_total++;
      if ((if_gc | ls_gc | cont_c) !== 32'h0)
         $display("FAIL reset_stats: got %0d/%0d/%0d want 0", if_gc, ls_gc, cont_c);
      else n_pass++;
`endif
      b.ls_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      m_streak = 0;
   endtask

   // One isolated access on the default instance with full observation.
   task automatic do_access(input string name, input bit is_ls, input bit we,
                            input logic [31:0] addr, input logic [31:0] wdata);
      exp_t e, w;
      bit rsv, done;
      int cyc, n_rd, n_wr, n_other, bad_addr, bad_wdata;
      logic [31:0] other_rd, got_rd, other_now;
      logic got_err;
      rsv = (addr <= ADDR_RESERVED_MAX);
      e.lat   = rsv ? 1 : 1 + RD_LAT;
      e.rdata = rsv ? 32'h0 : (we ? m_ls_rdata : rdata_fn(addr));
      e.err   = rsv;
      exp_q.push_back(e);
      other_rd = is_ls ? m_if_rdata : m_ls_rdata;
      cyc = 0; n_rd = 0; n_wr = 0; n_other = 0; bad_addr = 0; bad_wdata = 0; done = 0;
      got_rd = 32'h0; got_err = 1'b0;

      @(posedge clk); #1;
      if (is_ls) begin
         b.ls_req = 1'b1; b.ls_we = we; b.ls_addr = addr; b.ls_wdata = wdata;
      end else begin
         b.if_req = 1'b1; b.if_addr = addr;
      end
      while (!done && cyc <= 20) begin
         @(negedge clk);
         n_rd += int'(b.bus_read);
         n_wr += int'(b.bus_write);
         if ((b.bus_read || b.bus_write) && b.bus_addr !== addr) bad_addr++;
         if (b.bus_write && b.bus_wdata !== wdata) bad_wdata++;
         if (is_ls ? b.if_ack : b.ls_ack) n_other++;
         if (is_ls ? b.ls_ack : b.if_ack) begin
            done = 1;
            got_rd  = is_ls ? b.ls_rdata : b.if_rdata;
            got_err = is_ls ? b.ls_err : b.if_err;
         end else begin
            cyc++;
         end
      end
      other_now = is_ls ? b.if_rdata : b.ls_rdata;
      @(posedge clk); #1;
      b.if_req = 1'b0; b.ls_req = 1'b0;

      w = exp_q.pop_front();
      n_total++;
      if (!done) begin
         $display("FAIL %s timeout: no ack within %0d cycles, required ack", name, cyc);
         return;
      end else n_pass++;
      n_total++;
      if (cyc !== w.lat) $display("FAIL %s latency: got %0d want %0d", name, cyc, w.lat);
      else n_pass++;
      n_total++;
      if (got_rd !== w.rdata) $display("FAIL %s rdata: got %h want %h", name, got_rd, w.rdata);
      else n_pass++;
      n_total++;
      if (got_err !== w.err) $display("FAIL %s err: got %b want %b", name, got_err, w.err);
      else n_pass++;
      n_total++;
      if (n_rd !== ((rsv || we) ? 0 : RD_LAT))
         $display("FAIL %s read_cycles: got %0d want %0d", name, n_rd, (rsv || we) ? 0 : RD_LAT);
      else n_pass++;
      n_total++;
      if (n_wr !== ((!rsv && we) ? 1 : 0))
         $display("FAIL %s write_pulses: got %0d want %0d", name, n_wr, (!rsv && we) ? 1 : 0);
      else n_pass++;
      n_total++;
      if (bad_addr !== 0 || bad_wdata !== 0)
         $display("FAIL %s bus_addr_wdata: got %0d/%0d bad cycles want 0", name, bad_addr, bad_wdata);
      else n_pass++;
      n_total++;
      if (n_other !== 0 || other_now !== other_rd)
         $display("FAIL %s other_port: got %0d acks rdata %h want 0 acks rdata %h", name, n_other, other_now, other_rd);
      else n_pass++;

      if (rsv || !we) begin
         if (is_ls) m_ls_rdata = w.rdata;
         else m_if_rdata = w.rdata;
      end
      m_streak = 0;
   endtask

   // Hold the chosen requests continuously for n grants and check order.
   task automatic run_held(input string name, input bit ifr, input bit lsr, input int n);
      port_t p, got_p;
      int cyc, k, limit;
      logic [31:0] want, got_rd;
      for (int i = 0; i < n; i++) begin
         if (ifr && lsr && m_streak < MAX_STREAK) begin
            p = PORT_LS; m_streak++;
         end else if (lsr && !ifr) begin
            p = PORT_LS; m_streak = 0;
         end else begin
            p = PORT_IF; m_streak = 0;
         end
         ord_q.push_back(p);
      end
      limit = 1 + RD_LAT + n * (RD_LAT + 2) + 10;
      cyc = 0; k = 0;
      @(posedge clk); #1;
      b.if_req = ifr; b.if_addr = IF_A;
      b.ls_req = lsr; b.ls_we = 1'b0; b.ls_addr = LS_A;
      while (k < n && cyc <= limit) begin
         @(negedge clk);
         if (b.if_ack || b.ls_ack) begin
            n_total++;
            if (b.if_ack && b.ls_ack) $display("FAIL %s dual_ack: got both acks want one", name);
            else n_pass++;
            got_p  = b.ls_ack ? PORT_LS : PORT_IF;
            got_rd = b.ls_ack ? b.ls_rdata : b.if_rdata;
            p = ord_q.pop_front();
            want = rdata_fn(p == PORT_LS ? LS_A : IF_A);
            n_total++;
            if (got_p !== p) $display("FAIL %s grant_%0d: got %s want %s", name, k, got_p.name(), p.name());
            else n_pass++;
            n_total++;
            if (cyc !== 1 + RD_LAT + k * (RD_LAT + 2))
               $display("FAIL %s ack_time_%0d: got %0d want %0d", name, k, cyc, 1 + RD_LAT + k * (RD_LAT + 2));
            else n_pass++;
            n_total++;
            if (got_rd !== want) $display("FAIL %s rdata_%0d: got %h want %h", name, k, got_rd, want);
            else n_pass++;
            if (got_p == PORT_LS) m_ls_rdata = want;
            else m_if_rdata = want;
            k++;
         end
         cyc++;
      end
      if (k < n) begin
         n_total++;
         $display("FAIL %s timeout: got %0d acks want %0d", name, k, n);
         ord_q.delete();
      end
      @(posedge clk); #1;
      b.if_req = 1'b0; b.ls_req = 1'b0;
   endtask

   task automatic test_load();
      do_access("ls_load", 1'b1, 1'b0, 32'h1001_0000, 32'h0);
   endtask

   task automatic test_store();
      do_access("ls_store", 1'b1, 1'b1, 32'h1001_0024, 32'h0000_0055);
   endtask

   task automatic test_reserved();
      do_access("if_above_rsvd", 1'b0, 1'b0, 32'h0040_0000, 32'h0);
      do_access("if_rsvd",       1'b0, 1'b0, 32'h0000_1000, 32'h0);
      do_access("if_high_addr",  1'b0, 1'b0, 32'hF000_0000, 32'h0);
      do_access("if_rsvd_max",   1'b0, 1'b0, 32'h003F_FFFF, 32'h0);
      do_access("ls_rsvd_store", 1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_0001);
   endtask

   task automatic test_contention();
      run_held("both_held", 1'b1, 1'b1, 10);
   endtask

`ifdef MEM_BUS_ARB_STATS_EN
   task automatic test_stats();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      m_streak = 0;
      run_held("stats_both", 1'b1, 1'b1, 4);
      run_held("stats_if",   1'b1, 1'b0, 3);
      run_held("stats_ls",   1'b0, 1'b1, 1);
      @(negedge clk);
      n_total++;
      if (if_gc !== 32'd3 || ls_gc !== 32'd5 || cont_c !== 32'd4)
         $display("FAIL stats_counts: got %0d/%0d/%0d want 3/5/4", if_gc, ls_gc, cont_c);
      else n_pass++;
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      n_total++;
      if ((if_gc | ls_gc | cont_c) !== 32'h0)
         $display("FAIL stats_clear: got %0d/%0d/%0d want 0", if_gc, ls_gc, cont_c);
      else n_pass++;
      @(posedge clk); #1 rst = 1'b0;
      m_streak = 0;
   endtask
`endif

   // Reset lands while the RD_LATENCY=3 instance is mid-ACCESS.
   task automatic test_reset_mid_access();
      int acks, n_wr, cyc, bad;
      bit done;
      rst3 = 1'b0;
      @(posedge clk); #1;
      b3.ls_req = 1'b1; b3.ls_we = 1'b0; b3.ls_addr = 32'h1001_0000;
      @(negedge clk);
      @(negedge clk);
      n_total++;
      if (b3.bus_read !== 1'b1) $display("FAIL rst_mid reach_access: got bus_read %b want 1", b3.bus_read);
      else n_pass++;
      rst3 = 1'b1; b3.ls_req = 1'b0;
      @(negedge clk);
      n_total++;
      if ({b3.bus_read, b3.bus_write, b3.ls_ack, b3.if_ack} !== 4'b0 || dut3.state_q !== IDLE)
         $display("FAIL rst_mid drop: got strobes/acks %b state %s want 0000 IDLE",
                  {b3.bus_read, b3.bus_write, b3.ls_ack, b3.if_ack}, dut3.state_q.name());
      else n_pass++;
      @(posedge clk); #1 rst3 = 1'b0;
      acks = 0;
      repeat (6) begin
         @(negedge clk);
         acks += int'(b3.ls_ack | b3.if_ack | b3.bus_read | b3.bus_write);
      end
      n_total++;
      if (acks !== 0) $display("FAIL rst_mid abandoned: got %0d active cycles want 0", acks);
      else n_pass++;

      @(posedge clk); #1;
      b3.ls_req = 1'b1; b3.ls_we = 1'b1; b3.ls_addr = 32'h1001_0024; b3.ls_wdata = 32'h55;
      cyc = 0; n_wr = 0; bad = 0; done = 0;
      while (!done && cyc <= 20) begin
         @(negedge clk);
         n_wr += int'(b3.bus_write);
         if (b3.bus_write && (b3.bus_wdata !== 32'h55 || b3.bus_addr !== 32'h1001_0024)) bad++;
         if (b3.ls_ack) done = 1;
         else cyc++;
      end
      @(posedge clk); #1 b3.ls_req = 1'b0;
      n_total++;
      if (!done || cyc !== 1 + RD_LAT3)
         $display("FAIL rst_mid after_latency: got %0d (ack %b) want %0d", cyc, done, 1 + RD_LAT3);
      else n_pass++;
      n_total++;
      if (n_wr !== 1 || bad !== 0)
         $display("FAIL rst_mid after_write: got %0d pulses %0d bad want 1 pulse 0 bad", n_wr, bad);
      else n_pass++;
   endtask

   initial begin
      rst = 1'b1; rst3 = 1'b1;
      b.if_req = 1'b0; b.if_addr = 32'h0;
      b.ls_req = 1'b0; b.ls_we = 1'b0; b.ls_addr = 32'h0; b.ls_wdata = 32'h0;
      b3.if_req = 1'b0; b3.if_addr = 32'h0;
      b3.ls_req = 1'b0; b3.ls_we = 1'b0; b3.ls_addr = 32'h0; b3.ls_wdata = 32'h0;

      test_reset();
      test_load();
      test_store();
      test_reserved();
      test_contention();
`ifdef MEM_BUS_ARB_STATS_EN
      test_stats();
`endif
      test_reset_mid_access();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
